// File: rtl/sdram_read_cache.sv
// rtl/sdram_read_cache.sv - direct-mapped write-through read cache in front of the SDRAM controller
// Define SDRAM_CACHE_FLUSH_EN to add the i_flush input that invalidates every line.
module sdram_read_cache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SDRAM_CACHE_FLUSH_EN
    input  logic        i_flush,
`endif
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [21:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_mem_cyc,
    output logic        o_mem_stb,
    output logic        o_mem_we,
    output logic [21:0] o_mem_addr,
    output logic [31:0] o_mem_data,
    output logic [3:0]  o_mem_sel,
    input  logic        i_mem_stall,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data
);
    localparam int TAG_BITS = 20 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_FILL, S_WRITE, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [21:0]           addr_q, addr_d;
    logic                  we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            sel_q, sel_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  mem_cyc_q, mem_cyc_d;
    logic                  mem_stb_q, mem_stb_d;
    logic                  abort_q, abort_d;
    logic [31:0]           rword_q, rword_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  flush_in;

    logic [31:0]           data_ram [LINES*4];
    logic [TAG_BITS-1:0]   tag_ram  [LINES];
    logic [31:0]           data_rd;
    logic [TAG_BITS-1:0]   tag_rd;

    logic                  accept;
    logic                  data_we;
    logic [INDEX_BITS+1:0] data_waddr;
    logic [31:0]           data_wdata;
    logic                  tag_we;
    logic                  hit;
    logic [INDEX_BITS-1:0] lu_index;
    logic [TAG_BITS-1:0]   lu_tag;

`ifdef SDRAM_CACHE_FLUSH_EN
    assign flush_in = i_flush;
`else
    assign flush_in = 1'b0;
`endif

    assign lu_index = addr_q[INDEX_BITS+1:2];
    assign lu_tag   = addr_q[21:INDEX_BITS+2];
    assign hit      = valid_q[lu_index] && (tag_rd == lu_tag);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    // Block RAMs: read only on accept, written only in LOOKUP/FILL, so ports never collide.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_rd <= data_ram[i_wb_addr[INDEX_BITS+1:0]];
            tag_rd  <= tag_ram[i_wb_addr[INDEX_BITS+1:2]];
        end
        if (data_we) begin
            data_ram[data_waddr] <= data_wdata;
        end
        if (tag_we) begin
            tag_ram[lu_index] <= lu_tag;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        mem_cyc_d    = mem_cyc_q;
        mem_stb_d    = mem_stb_q;
        abort_d      = abort_q;
        rword_d      = rword_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q | flush_in;
        accept       = 1'b0;
        data_we      = 1'b0;
        data_waddr   = addr_q[INDEX_BITS+1:0];
        data_wdata   = wdata_q;
        tag_we       = 1'b0;
        o_wb_stall   = 1'b1;
        o_wb_ack     = 1'b0;
        o_wb_data    = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (flush_pend_q) begin
                    valid_d      = '0;
                    flush_pend_d = flush_in;
                end else begin
                    o_wb_stall = 1'b0;
                    if (i_wb_cyc && i_wb_stb) begin
                        accept  = 1'b1;
                        addr_d  = i_wb_addr;
                        we_d    = i_wb_we;
                        wdata_d = i_wb_data;
                        sel_d   = i_wb_sel;
                        abort_d = 1'b0;
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                if (we_q) begin
                    if (hit) begin
                        data_we    = 1'b1;
                        data_wdata = merge_bytes(data_rd, wdata_q, sel_q);
                    end
                    abort_d   = !i_wb_cyc;
                    mem_cyc_d = 1'b1;
                    mem_stb_d = 1'b1;
                    state_d   = S_WRITE;
                end else if (hit) begin
                    o_wb_ack  = i_wb_cyc;
                    o_wb_data = i_wb_cyc ? data_rd : 32'h0;
                    state_d   = S_IDLE;
                end else begin
                    abort_d   = !i_wb_cyc;
                    cnt_d     = 2'd0;
                    mem_cyc_d = 1'b1;
                    mem_stb_d = 1'b1;
                    state_d   = S_FILL;
                end
            end
            S_FILL: begin
                if (!i_wb_cyc) begin
                    abort_d = 1'b1;
                end
                if (mem_stb_q && !i_mem_stall) begin
                    mem_stb_d = 1'b0;
                end
                if (i_mem_ack) begin
                    data_we    = 1'b1;
                    data_waddr = {lu_index, cnt_q};
                    data_wdata = i_mem_data;
                    if (cnt_q == addr_q[1:0]) begin
                        rword_d = i_mem_data;
                    end
                    if (cnt_q == 2'd3) begin
                        tag_we            = 1'b1;
                        valid_d[lu_index] = 1'b1;
                        mem_cyc_d         = 1'b0;
                        state_d           = abort_d ? S_IDLE : S_RESP;
                    end else begin
                        cnt_d     = cnt_q + 2'd1;
                        mem_stb_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (!i_wb_cyc) begin
                    abort_d = 1'b1;
                end
                if (mem_stb_q && !i_mem_stall) begin
                    mem_stb_d = 1'b0;
                end
                if (i_mem_ack) begin
                    mem_cyc_d = 1'b0;
                    state_d   = abort_d ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                o_wb_ack  = i_wb_cyc;
                o_wb_data = (i_wb_cyc && !we_q) ? rword_q : 32'h0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            sel_q        <= '0;
            cnt_q        <= '0;
            mem_cyc_q    <= 1'b0;
            mem_stb_q    <= 1'b0;
            abort_q      <= 1'b0;
            rword_q      <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            mem_cyc_q    <= mem_cyc_d;
            mem_stb_q    <= mem_stb_d;
            abort_q      <= abort_d;
            rword_q      <= rword_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Downstream fields are gated by cyc so they read as zero whenever the bus is idle.
    assign o_mem_cyc  = mem_cyc_q;
    assign o_mem_stb  = mem_stb_q;
    assign o_mem_we   = mem_cyc_q && we_q;
    assign o_mem_addr = !mem_cyc_q ? 22'h0 : (we_q ? addr_q : {addr_q[21:2], cnt_q});
    assign o_mem_data = (mem_cyc_q && we_q) ? wdata_q : 32'h0;
    assign o_mem_sel  = !mem_cyc_q ? 4'h0 : (we_q ? sel_q : 4'hF);

endmodule

// File: tb/tb_sdram_read_cache.sv
// tb/tb_sdram_read_cache.sv - directed table-driven bench for sdram_read_cache
module tb_sdram_read_cache;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
    logic [21:0] i_wb_addr = '0;
    logic [31:0] i_wb_data = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        o_wb_stall, o_wb_ack;
    logic [31:0] o_wb_data;
    logic        o_mem_cyc, o_mem_stb, o_mem_we;
    logic [21:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic [3:0]  o_mem_sel;
    logic        i_mem_stall = 1'b0, i_mem_ack = 1'b0;
    logic [31:0] i_mem_data = '0;
`ifdef SDRAM_CACHE_FLUSH_EN
    logic        i_flush = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sdram_read_cache #(.INDEX_BITS(6)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef SDRAM_CACHE_FLUSH_EN
        .i_flush(i_flush),
`endif
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
        .o_mem_cyc(o_mem_cyc), .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_sel(o_mem_sel),
        .i_mem_stall(i_mem_stall), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data)
    );

    // SDRAM model: unwritten words read as {10'h2A5, addr}; ack one cycle after acceptance.
    logic [31:0] sdram [logic [21:0]];
    int          stall_n = 0;
    int          stb_age = 0;
    bit          acc_pend = 1'b0;
    logic [21:0] acc_addr = '0;
    int          n_rd = 0;
    int          n_wr = 0;
    logic [21:0] last_wr_addr = '0;
    logic [21:0] rd_log [$];

    function automatic logic [31:0] sd_read(input logic [21:0] a);
        if (sdram.exists(a)) return sdram[a];
        return {10'h2A5, a};
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            i_mem_ack   = 1'b0;
            i_mem_stall = 1'b0;
            i_mem_data  = '0;
            acc_pend    = 1'b0;
            stb_age     = 0;
        end else begin
            i_mem_ack  = acc_pend;
            i_mem_data = acc_pend ? sd_read(acc_addr) : 32'h0;
            acc_pend   = 1'b0;
            if (o_mem_stb) begin
                i_mem_stall = (stb_age < stall_n);
                stb_age++;
                if (!i_mem_stall) begin
                    acc_pend = 1'b1;
                    acc_addr = o_mem_addr;
                    stb_age  = 0;
                    if (o_mem_we) begin
                        sdram[o_mem_addr] = byte_merge(sd_read(o_mem_addr), o_mem_data, o_mem_sel);
                        last_wr_addr = o_mem_addr;
                        n_wr++;
                    end else begin
                        rd_log.push_back(o_mem_addr);
                        n_rd++;
                    end
                end
            end else begin
                i_mem_stall = 1'b0;
                stb_age     = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_req(input bit we, input logic [21:0] a, input logic [31:0] d, input logic [3:0] sel,
                          output logic [31:0] rdata, output int lat, output int stalls,
                          output bit ack_after, output bit stall_after);
        @(negedge clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
        i_wb_addr = a; i_wb_data = d; i_wb_sel = sel;
        stalls = 0;
        while (o_wb_stall && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        @(posedge clk);
        #1 i_wb_stb = 1'b0;
        lat = 0;
        rdata = '0;
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
            if (o_wb_ack) begin
                lat = t;
                rdata = o_wb_data;
                break;
            end
        end
        @(negedge clk);
        ack_after = o_wb_ack;
        stall_after = o_wb_stall;
        i_wb_cyc = 1'b0;
    endtask

    typedef struct {
        bit          we;
        logic [21:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          stall;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [21:0] exp_maddr;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] rd;
        int          lat, stl, brd, bwr, bound;
        bit          ack2, stall2, seq_ok, saw_ack;

        vecs[0]  = '{1'b0, 22'h000010, 32'h0,        4'hF, 0, 32'hDEADBEEF, 10, 4, 0, 22'h000010};
        vecs[1]  = '{1'b0, 22'h000011, 32'h0,        4'hF, 0, 32'hA9400011, 1,  0, 0, 22'h0};
        vecs[2]  = '{1'b1, 22'h000012, 32'h0000ABCD, 4'h3, 0, 32'h0,        4,  0, 1, 22'h000012};
        vecs[3]  = '{1'b0, 22'h000012, 32'h0,        4'hF, 0, 32'hA940ABCD, 1,  0, 0, 22'h0};
        vecs[4]  = '{1'b0, 22'h000410, 32'h0,        4'hF, 0, 32'hA9400410, 10, 4, 0, 22'h000410};
        vecs[5]  = '{1'b0, 22'h000010, 32'h0,        4'hF, 0, 32'hDEADBEEF, 10, 4, 0, 22'h000010};
        vecs[6]  = '{1'b1, 22'h000050, 32'h12345678, 4'hF, 2, 32'h0,        6,  0, 1, 22'h000050};
        vecs[7]  = '{1'b0, 22'h000050, 32'h0,        4'hF, 1, 32'h12345678, 14, 4, 0, 22'h000050};
        vecs[8]  = '{1'b0, 22'h000053, 32'h0,        4'hF, 0, 32'hA9400053, 1,  0, 0, 22'h0};
        vecs[9]  = '{1'b1, 22'h000053, 32'hCAFE0000, 4'hC, 0, 32'h0,        4,  0, 1, 22'h000053};
        vecs[10] = '{1'b0, 22'h000053, 32'h0,        4'hF, 0, 32'hCAFE0053, 1,  0, 0, 22'h0};
        vecs[11] = '{1'b0, 22'h000012, 32'h0,        4'hF, 0, 32'hA940ABCD, 1,  0, 0, 22'h0};

        sdram[22'h000010] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        check("reset_stall",    {31'h0, o_wb_stall}, 32'h0);
        check("reset_ack",      {31'h0, o_wb_ack},   32'h0);
        check("reset_mem_cyc",  {31'h0, o_mem_cyc},  32'h0);
        check("reset_mem_stb",  {31'h0, o_mem_stb},  32'h0);
        check("reset_mem_addr", {10'h0, o_mem_addr}, 32'h0);
        check("reset_wb_data",  o_wb_data,           32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            stall_n = vecs[i].stall;
            brd = n_rd;
            bwr = n_wr;
            do_req(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel, rd, lat, stl, ack2, stall2);
            stall_n = 0;
            if (!vecs[i].we) check($sformatf("v%0d_data", i), rd, vecs[i].exp_data);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_mem_reads", i), n_rd - brd, vecs[i].exp_rd);
            check($sformatf("v%0d_mem_writes", i), n_wr - bwr, vecs[i].exp_wr);
            check($sformatf("v%0d_ack_single", i), {31'h0, ack2}, 32'h0);
            check($sformatf("v%0d_idle_after", i), {31'h0, stall2}, 32'h0);
            if (vecs[i].exp_wr > 0)
                check($sformatf("v%0d_wr_addr", i), {10'h0, last_wr_addr}, {10'h0, vecs[i].exp_maddr});
            if (vecs[i].exp_rd > 0 && n_rd - brd == 4) begin
                seq_ok = 1'b1;
                for (int k = 0; k < 4; k++)
                    if (rd_log[brd + k] !== (vecs[i].exp_maddr + 22'(k))) seq_ok = 1'b0;
                check($sformatf("v%0d_fill_order", i), {31'h0, seq_ok}, 32'h1);
            end
        end

        // Upstream cyc drops after the 2nd fill read: fill completes silently and is installed.
        brd = n_rd;
        @(negedge clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 22'h000090;
        @(posedge clk);
        #1 i_wb_stb = 1'b0;
        bound = 0;
        do begin
            @(negedge clk);
            #1 bound++;
        end while ((n_rd - brd) < 2 && bound < 50);
        i_wb_cyc = 1'b0;
        saw_ack = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (o_wb_ack) saw_ack = 1'b1;
        end
        check("abort_no_ack",     {31'h0, saw_ack},    32'h0);
        check("abort_mem_reads",  n_rd - brd,          32'd4);
        check("abort_idle",       {31'h0, o_wb_stall}, 32'h0);
        brd = n_rd;
        do_req(1'b0, 22'h000091, 32'h0, 4'hF, rd, lat, stl, ack2, stall2);
        check("abort_fill_hit_data", rd,         32'hA9400091);
        check("abort_fill_hit_lat",  lat,        32'd1);
        check("abort_fill_no_reads", n_rd - brd, 32'd0);

        // Reset while the 2nd fill read is on the bus.
        brd = n_rd;
        @(negedge clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 22'h0000D0;
        @(posedge clk);
        #1 i_wb_stb = 1'b0;
        bound = 0;
        do begin
            @(negedge clk);
            #1 bound++;
        end while (!(o_mem_stb && (n_rd - brd) == 2) && bound < 50);
        check("rst_mid_reached", {31'h0, o_mem_stb}, 32'h1);
        #1 rst_n = 1'b0;
        i_wb_cyc = 1'b0;
        #1;
        check("rst_mid_mem_cyc", {31'h0, o_mem_cyc},  32'h0);
        check("rst_mid_mem_stb", {31'h0, o_mem_stb},  32'h0);
        check("rst_mid_stall",   {31'h0, o_wb_stall}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        brd = n_rd;
        do_req(1'b0, 22'h0000D1, 32'h0, 4'hF, rd, lat, stl, ack2, stall2);
        check("rst_refill_data",  rd,         32'hA94000D1);
        check("rst_refill_lat",   lat,        32'd10);
        check("rst_refill_reads", n_rd - brd, 32'd4);
        brd = n_rd;
        do_req(1'b0, 22'h000011, 32'h0, 4'hF, rd, lat, stl, ack2, stall2);
        check("rst_valid_clear_lat",   lat,        32'd10);
        check("rst_valid_clear_reads", n_rd - brd, 32'd4);

`ifdef SDRAM_CACHE_FLUSH_EN
        // Line 0x10 was refilled just above; a flush pulse must force a miss after one stall cycle.
        do_req(1'b0, 22'h000010, 32'h0, 4'hF, rd, lat, stl, ack2, stall2);
        check("flush_pre_hit_lat", lat, 32'd1);
        @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk);
        #1 i_flush = 1'b0;
        brd = n_rd;
        do_req(1'b0, 22'h000010, 32'h0, 4'hF, rd, lat, stl, ack2, stall2);
        check("flush_stall_cycles", stl,        32'd1);
        check("flush_miss_lat",     lat,        32'd10);
        check("flush_miss_reads",   n_rd - brd, 32'd4);
        check("flush_miss_data",    rd,         32'hDEADBEEF);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
